// File: rtl/lights_ctrl.sv
// Push-button / auto-cycle front end for the LED lights block: synchronises and
// debounces a raw button, arbitrates manual vs automatic stepping, mirrors the colour.
module lights_ctrl #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       auto_en,
  input  logic [7:0] period,
  output logic       button,
  output logic [1:0] mode,
  output logic [7:0] step_cnt,
  output logic [2:0] colour_est
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_AUTO   = 2'b10
  } state_t;

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_btn_db;
  logic [3:0] r_db_cnt;
  state_t     r_state;
  logic       r_button;
  logic [7:0] r_pcnt;
  logic [7:0] r_step_cnt;
  logic [2:0] r_colour;
  state_t     w_next;

  // The debounced button always wins; MANUAL can only fall back to IDLE.
  function automatic state_t next_state(input state_t cur, input logic btn, input logic aen);
    state_t nxt;
    case (cur)
      ST_IDLE:   nxt = btn ? ST_MANUAL : (aen ? ST_AUTO : ST_IDLE);
      ST_MANUAL: nxt = btn ? ST_MANUAL : ST_IDLE;
      ST_AUTO:   nxt = btn ? ST_MANUAL : (aen ? ST_AUTO : ST_IDLE);
      default:   nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] colour_step(input logic [2:0] c);
    return (c == 3'b111) ? 3'b001 : c + 3'd1;
  endfunction

  assign w_next = next_state(r_state, r_btn_db, auto_en);

  // Two-flop synchroniser followed by a stable-for-DB_CYCLES debouncer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_btn_db <= 1'b0;
      r_db_cnt <= 4'd0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
      if (r_s2 == r_btn_db) begin
        r_db_cnt <= 4'd0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_db <= ~r_btn_db;
        r_db_cnt <= 4'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 4'd1;
      end
    end
  end

  // Mode FSM with registered step request; pcnt only runs while staying in AUTO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_button <= 1'b0;
      r_pcnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      case (w_next)
        ST_MANUAL: begin
          r_button <= 1'b1;
          r_pcnt   <= 8'd0;
        end
        ST_AUTO: begin
          if (r_state != ST_AUTO) begin
            r_button <= 1'b0;
            r_pcnt   <= 8'd0;
          end else if (r_pcnt == period) begin
            r_button <= 1'b1;
            r_pcnt   <= 8'd0;
          end else begin
            r_button <= 1'b0;
            r_pcnt   <= r_pcnt + 8'd1;
          end
        end
        default: begin
          r_button <= 1'b0;
          r_pcnt   <= 8'd0;
        end
      endcase
    end
  end

  // Step counter and colour mirror advance once per cycle the request is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_cnt <= 8'd0;
      r_colour   <= 3'b001;
    end else if (r_button) begin
      r_step_cnt <= r_step_cnt + 8'd1;
      r_colour   <= colour_step(r_colour);
    end else begin
      r_step_cnt <= r_step_cnt;
      r_colour   <= r_colour;
    end
  end

  assign button     = r_button;
  assign mode       = r_state;
  assign step_cnt   = r_step_cnt;
  assign colour_est = r_colour;

endmodule

// File: tb/tb_lights_ctrl.sv
// Randomised bench for lights_ctrl against a sliding-window / arithmetic reference model.
module tb_lights_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_in = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] period = 8'd0;
  wire        button;
  wire  [1:0] mode;
  wire  [7:0] step_cnt;
  wire  [2:0] colour_est;

  lights_ctrl #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .auto_en(auto_en), .period(period),
    .button(button), .mode(mode), .step_cnt(step_cnt), .colour_est(colour_est)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 manual, 2 auto.
  int m_mode, m_pcnt, m_step, m_colour;
  bit m_button, m_db;
  bit m_hist[$];   // btn_in sampled at each edge, newest first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pcnt = 0; m_step = 0; m_colour = 1; m_button = 1'b0; m_db = 1'b0;
    m_hist.delete();
    for (int k = 0; k < DB + 2; k++) m_hist.push_front(1'b0);
  endtask

  // The synchronised value seen at this edge is btn_in from two edges ago;
  // the debounced level flips once the last DB such values all disagree with it.
  task automatic model_edge();
    bit flip;
    int nxt;
    flip = 1'b1;
    for (int j = 1; j <= DB; j++) if (m_hist[j] == m_db) flip = 1'b0;
    if (m_db) nxt = 1;
    else if (m_mode == 1) nxt = 0;
    else if (auto_en) nxt = 2;
    else nxt = 0;
    if (m_button) begin
      m_step = (m_step + 1) % 256;
      m_colour = m_colour % 7 + 1;
    end
    if (nxt == 2 && m_mode == 2) begin
      if (m_pcnt == int'(period)) begin m_button = 1'b1; m_pcnt = 0; end
      else begin m_button = 1'b0; m_pcnt = (m_pcnt + 1) % 256; end
    end else begin
      m_button = (nxt == 1);
      m_pcnt = 0;
    end
    m_mode = nxt;
    if (flip) m_db = !m_db;
    m_hist.push_front(btn_in);
    void'(m_hist.pop_back());
  endtask

  task automatic check_all();
    chk("mode", mode, m_mode);
    chk("button", button, m_button);
    chk("step_cnt", step_cnt, m_step);
    chk("colour_est", colour_est, m_colour);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_button"}, button, 0);
    chk({tag, "_step"}, step_cnt, 0);
    chk({tag, "_colour"}, colour_est, 1);
  endtask

  // One clock: drive inputs mid-cycle, advance model at the edge, compare 1 ns later.
  task automatic step(input logic b, input logic a, input logic [7:0] p);
    btn_in = b; auto_en = a; period = p;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges, held across one edge, released mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 chk_reset_vals("rst_async");
    model_reset();
    @(posedge clk);
    #1 chk_reset_vals("rst_hold");
    #3 rst = 1'b1;
  endtask

  int hi_cnt;
  int len;
  logic rb, ra;
  logic [7:0] rp;
  int prev_mode;

  initial begin
    model_reset();
    @(posedge clk);
    #1 chk_reset_vals("init");
    #3 rst = 1'b1;

    // Manual press: request and mode rise at edge 7, colour wraps after 7 steps.
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 8'd0);
      if (i == 6) chk("man_e6_mode", mode, 0);
      if (i == 7) begin chk("man_e7_mode", mode, 1); chk("man_e7_button", button, 1); end
      if (i == 8) chk("man_e8_colour", colour_est, 2);
      if (i == 14) begin chk("man_e14_colour", colour_est, 1); chk("man_e14_step", step_cnt, 7); end
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'd0);

    // Glitch of 3 cycles never reaches the debounced level.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 8'd0);
      chk("glitch_mode", mode, 0);
    end

    // Auto cycling with period 3.
    auto_en = 1'b1; period = 8'd3;
    do_reset();
    step(1'b0, 1'b1, 8'd3);
    chk("auto_entry_mode", mode, 2);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'd3);
      if (button) hi_cnt++;
    end
    chk("auto_pulses_20", hi_cnt, 5);

    // Pre-emption from AUTO, then release back through IDLE.
    prev_mode = mode;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'd3);
    chk("preempt_mode", mode, 1);
    prev_mode = mode;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'd3);
      if (prev_mode == 1) chk("no_manual_to_auto", (mode != 2'd2), 1);
      prev_mode = mode;
    end

    // Async reset in MANUAL at step_cnt 9.
    do_reset();
    for (int i = 0; i < 60 && step_cnt != 8'd9; i++) step(1'b1, 1'b0, 8'd0);
    chk("reach_step9", step_cnt, 9);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0);

    // Step counter wrap over 256 requests.
    for (int i = 1; i <= 266; i++) begin
      step(1'b1, 1'b0, 8'd0);
      if (i == 262) chk("wrap_255", step_cnt, 255);
      if (i == 263) chk("wrap_0", step_cnt, 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'd0);

    // period 0 keeps the request high every AUTO cycle.
    auto_en = 1'b1; period = 8'd0;
    do_reset();
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'd0);
      chk("p0_button", button, 1);
    end

    // Randomised phases: holds, glitches, live period changes, occasional reset.
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(1, 25);
      rb = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rp = 8'($urandom_range(0, 255));
      else rp = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 40) == 0) do_reset();
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) rp = 8'($urandom_range(0, 6));
        step(rb, ra, rp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
